spi_req_exec: RTL and testbench
===============================

// Module: spi_req_exec
// PURPOSE
//  Executor on the spi_req_inf slave side: takes one request from a command module (e.g. set-DQ,
//  read, program), drives CS#/SCLK/DQ[3:0] to the flash in SPI mode 0, streams write nibbles,
//  captures read nibbles. Sits between all command modules (via arbiter mux) and the pad ring.
// PARAMETERS
//  CLK_DIV     2   clocks per SCLK half-period (>=1); SCLK period = 2*CLK_DIV clocks
//  CS_SETUP    2   clocks CS# low before first SCLK rise
//  CS_HOLD     2   clocks after last SCLK fall before CS# high
//  CS_GAP      4   min clocks CS# high before the next request may start
// PORTS
//  clock       in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  lane_mode   in   2   0=X1 1=X2 2=X4 (3 treated as X1); sampled at request accept
//  request     in   1   request level, held by requester until busy seen
//  req_cmd     in   3   bit0=1 forces X1 regardless of lane_mode; bits[2:1] reserved, ignored
//  req_len     in   24  total nibble (SCLK) cycles in transfer
//  req_wr_len  in   24  leading nibble cycles that are writes; rest are reads
//  busy        out  1   high from accept until CS_GAP expires
//  clk_en      out  1   1-cycle strobe at start of each byte slot (2 SCLK periods)
//  wr_ready    out  1   high while >=1 write nibble remains in current request
//  wr_vld      in   1   write data valid
//  wr_data     in   8   two nibbles, [7:4] sent first; each nibble = DQ[3:0] for one SCLK
//  rd_data     out  8   captured read byte, first nibble in [7:4]
//  rd_vld      out  1   1-cycle pulse per rd_data byte
//  sclk        out  1   flash clock, idle low
//  cs_n        out  1   flash chip select, idle high
//  dq_out      out  4   DQ drive values
//  dq_oe       out  4   DQ output enables
//  dq_in       in   4   DQ pad inputs
// BEHAVIOUR
//  Reset (rst=1 at any edge, incl. mid-transfer): state IDLE, busy=0, clk_en=0, wr_ready=0,
//   rd_vld=0, rd_data=0, sclk=0, cs_n=1, dq_out=0, dq_oe=0; partial data discarded.
//  FSM IDLE->SETUP->SHIFT->HOLD->GAP->IDLE.
//  IDLE: request=1 -> latch lanes, req_len, wlen=min(req_wr_len,req_len); busy=1 next cycle.
//   req_len==0 -> straight to GAP, cs_n never falls.
//  SETUP: cs_n=0 for CS_SETUP clocks, sclk low. SHIFT: nibble counter 0..req_len-1.
//  Nibble timing: dq_out updated while sclk low (start of low half); sclk rises after CLK_DIV
//   clocks; dq_in sampled on the clock sclk rises; falls after another CLK_DIV.
//  Byte slot = 2 nibbles; clk_en pulses on first clock of each slot's low half.
//  Write handshake: byte taken when wr_vld&clk_en&wr_ready; [7:4] then [3:0] shifted.
//   If wr_vld=0 at that clk_en: stall with sclk low, cs_n low; clk_en re-pulses every
//   2*CLK_DIV clocks until taken. Odd wlen: lower nibble of last byte ignored.
//  Lane mask: X1 oe=0001, X2 oe=0011, X4 oe=1111 during write nibbles; oe=0000 during reads.
//  Read nibble: X1 {3'b000,dq_in[1]}, X2 {2'b00,dq_in[1:0]}, X4 dq_in; packed two per byte,
//   rd_vld one clock after 2nd nibble sample; odd count -> final byte low nibble 0, still pulsed.
//   Read nibble starting a byte slot on a write/read boundary starts a fresh byte.
//  HOLD: after last sclk fall, CS_HOLD clocks then cs_n=1, dq_oe=0.
//  GAP: cs_n high CS_GAP clocks, then busy=0. request ignored while busy=1.
//  Counters 24-bit unsigned, no wrap: req_len up to 2^24-1 supported.
// STRUCTURE
//  spi_flash_pkg: typedef enum {LANE_X1,LANE_X2,LANE_X4} lane_e; REQ_CMD_X1 = 3'b001.
//  Sub-module spi_clk_gen: CLK_DIV counter, produces sclk, rise/fall strobes, run/stall input.
// TESTING
//  X4, req_len=4, wr_len=4, bytes 61,47 -> dq_out 6,1,4,7 on 4 sclk rises, oe=1111, busy drops.
//  X1 (req_cmd=001), len=16, wr_len=16, bytes {0,b,0,b} -> dq_out[0] shows 0x6147 MSB first.
//  X2, len=6 wr_len=2, dq_in[1:0]=1,2,3,0 -> rd_data 0x12,0x30, two rd_vld pulses.
//  wr_vld low for 3 slots mid-write -> sclk frozen low, cs_n low, resumes without nibble loss.
//  req_len=0 -> busy high CS_GAP+1 clocks, cs_n stays 1, no clk_en.
//  rst asserted during SHIFT -> next clock cs_n=1, sclk=0, busy=0; new request runs clean.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and lane helpers for the SPI flash request executor.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    LaneX1 = 2'd0,
    LaneX2 = 2'd1,
    LaneX4 = 2'd2
  } lane_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  localparam logic [2:0] ReqCmdX1 = 3'b001;

  // Upper command bits are reserved; only the X1-override bit matters.
  function automatic lane_e decode_lane(input logic [1:0] mode, input logic [2:0] cmd);
    lane_e lane;
    unique case (mode)
      2'd1:    lane = LaneX2;
      2'd2:    lane = LaneX4;
      default: lane = LaneX1;
    endcase
    if ((cmd & ReqCmdX1) != 3'b000) lane = LaneX1;
    return lane;
  endfunction

  function automatic logic [3:0] lane_oe(input lane_e lane);
    unique case (lane)
      LaneX2:  return 4'b0011;
      LaneX4:  return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  // X1 reads come back on DQ1 (flash SO), wider modes use the low lanes.
  function automatic logic [3:0] rd_nibble(input lane_e lane, input logic [3:0] dq);
    unique case (lane)
      LaneX2:  return {2'b00, dq[1:0]};
      LaneX4:  return dq;
      default: return {3'b000, dq[1]};
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: one period is ClkDiv low clocks then ClkDiv high clocks.
// A stalled period runs the same length but keeps SCLK low and suppresses strobes.
module spi_clk_gen #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic stall_i,
  output logic sclk_o,
  output logic start_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            hold_q, hold_d;
  logic            hold_eff, half_end;

  always_comb begin
    start_o  = run_i & ~phase_q & (cnt_q == '0);
    hold_eff = start_o ? stall_i : hold_q;
    half_end = (cnt_q == CntMax);
    rise_o   = run_i & ~phase_q & half_end & ~hold_eff;
    fall_o   = run_i & phase_q & half_end & ~hold_eff;
    sclk_o   = phase_q & ~hold_q;

    cnt_d   = cnt_q;
    phase_d = phase_q;
    hold_d  = hold_eff;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      hold_d  = 1'b0;
    end else if (half_end) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/spi_req_exec.sv
// Executes one spi_req_inf request: CS# framing, mode-0 SCLK, write nibble streaming
// and read nibble capture, then enforces a minimum CS# high gap.
module spi_req_exec
  import spi_flash_pkg::*;
#(
  parameter int unsigned ClkDiv  = 2,
  parameter int unsigned CsSetup = 2,
  parameter int unsigned CsHold  = 2,
  parameter int unsigned CsGap   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  lane_mode_i,
  input  logic        request_i,
  input  logic [2:0]  req_cmd_i,
  input  logic [23:0] req_len_i,
  input  logic [23:0] req_wr_len_i,
  output logic        busy_o,
  output logic        clk_en_o,
  output logic        wr_ready_o,
  input  logic        wr_vld_i,
  input  logic [7:0]  wr_data_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_vld_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic [3:0]  dq_out_o,
  output logic [3:0]  dq_oe_o,
  input  logic [3:0]  dq_in_i
);

  localparam int unsigned TmrW = 16;

  state_e          state_q, state_d;
  lane_e           lane_q, lane_d;
  logic [23:0]     len_q, len_d, wlen_q, wlen_d, nib_q, nib_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [3:0]      wr_lo_q, wr_lo_d, rd_hi_q, rd_hi_d;
  logic            rd_half_q, rd_half_d, rd_vld_q, rd_vld_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [3:0]      dq_out_q, dq_out_d, dq_oe_q, dq_oe_d;

  logic run, stall, start, rise, fall, need_wr, last_nib;
  logic [3:0] rd_nib;

  spi_clk_gen #(
    .ClkDiv (ClkDiv)
  ) u_clk_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run),
    .stall_i (stall),
    .sclk_o  (sclk_o),
    .start_o (start),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_comb begin
    run      = (state_q == StShift);
    need_wr  = (nib_q < wlen_q);
    last_nib = (nib_q == len_q - 24'd1);
    rd_nib   = rd_nibble(lane_q, dq_in_i);
    // Byte slots start on even nibbles; a missing write byte freezes the whole period.
    clk_en_o = start & ~nib_q[0];
    stall    = clk_en_o & need_wr & ~wr_vld_i;

    state_d   = state_q;
    lane_d    = lane_q;
    len_d     = len_q;
    wlen_d    = wlen_q;
    nib_d     = nib_q;
    tmr_d     = tmr_q;
    wr_lo_d   = wr_lo_q;
    rd_hi_d   = rd_hi_q;
    rd_half_d = rd_half_q;
    rd_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    dq_out_d  = dq_out_q;
    dq_oe_d   = dq_oe_q;

    unique case (state_q)
      StIdle: begin
        if (request_i) begin
          lane_d    = decode_lane(lane_mode_i, req_cmd_i);
          len_d     = req_len_i;
          wlen_d    = (req_wr_len_i < req_len_i) ? req_wr_len_i : req_len_i;
          nib_d     = '0;
          rd_half_d = 1'b0;
          if (req_len_i == '0) begin
            state_d = StGap;
            tmr_d   = TmrW'(CsGap);
          end else begin
            state_d = StSetup;
            tmr_d   = TmrW'(CsSetup - 1);
          end
        end
      end
      StSetup: begin
        if (tmr_q == '0) state_d = StShift;
        else tmr_d = tmr_q - 1'b1;
      end
      StShift: begin
        if (start && !stall) begin
          if (need_wr) begin
            dq_out_d = nib_q[0] ? wr_lo_q : wr_data_i[7:4];
            if (!nib_q[0]) wr_lo_d = wr_data_i[3:0];
            dq_oe_d = lane_oe(lane_q);
          end else begin
            dq_out_d = '0;
            dq_oe_d  = '0;
          end
        end
        if (rise && !need_wr) begin
          if (rd_half_q) begin
            rd_data_d = {rd_hi_q, rd_nib};
            rd_vld_d  = 1'b1;
            rd_half_d = 1'b0;
          end else if (last_nib) begin
            rd_data_d = {rd_nib, 4'h0};
            rd_vld_d  = 1'b1;
          end else begin
            rd_hi_d   = rd_nib;
            rd_half_d = 1'b1;
          end
        end
        if (fall) begin
          if (last_nib) begin
            state_d = StHold;
            tmr_d   = TmrW'(CsHold - 1);
          end else begin
            nib_d = nib_q + 24'd1;
          end
        end
      end
      StHold: begin
        if (tmr_q == '0) begin
          state_d  = StGap;
          tmr_d    = TmrW'(CsGap - 1);
          dq_out_d = '0;
          dq_oe_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StGap: begin
        if (tmr_q == '0) state_d = StIdle;
        else tmr_d = tmr_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      lane_q    <= LaneX1;
      len_q     <= '0;
      wlen_q    <= '0;
      nib_q     <= '0;
      tmr_q     <= '0;
      wr_lo_q   <= '0;
      rd_hi_q   <= '0;
      rd_half_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      len_q     <= len_d;
      wlen_q    <= wlen_d;
      nib_q     <= nib_d;
      tmr_q     <= tmr_d;
      wr_lo_q   <= wr_lo_d;
      rd_hi_q   <= rd_hi_d;
      rd_half_q <= rd_half_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign cs_n_o     = !((state_q == StSetup) || (state_q == StShift) || (state_q == StHold));
  assign wr_ready_o = ((state_q == StSetup) || (state_q == StShift)) && need_wr;
  assign rd_data_o  = rd_data_q;
  assign rd_vld_o   = rd_vld_q;
  assign dq_out_o   = dq_out_q;
  assign dq_oe_o    = dq_oe_q;

endmodule

// File: tb/tb_spi_req_exec.sv
// Scoreboard bench for spi_req_exec: expected nibbles and read bytes are queued per request
// and popped by monitors on each SCLK rise / rd_vld pulse.
module tb_spi_req_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  lane_mode;
  logic        request;
  logic [2:0]  req_cmd;
  logic [23:0] req_len, req_wr_len;
  logic        busy, clk_en, wr_ready, wr_vld, rd_vld, sclk, cs_n;
  logic [7:0]  wr_data, rd_data;
  logic [3:0]  dq_out, dq_oe, dq_in;

  spi_req_exec dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .lane_mode_i  (lane_mode),
    .request_i    (request),
    .req_cmd_i    (req_cmd),
    .req_len_i    (req_len),
    .req_wr_len_i (req_wr_len),
    .busy_o       (busy),
    .clk_en_o     (clk_en),
    .wr_ready_o   (wr_ready),
    .wr_vld_i     (wr_vld),
    .wr_data_i    (wr_data),
    .rd_data_o    (rd_data),
    .rd_vld_o     (rd_vld),
    .sclk_o       (sclk),
    .cs_n_o       (cs_n),
    .dq_out_o     (dq_out),
    .dq_oe_o      (dq_oe),
    .dq_in_i      (dq_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_nib[$];  // {oe, dq} seen at each SCLK rise
  logic [7:0] exp_rd[$];
  logic [3:0] rd_in[$];
  logic [7:0] wr_q[$];
  int skip_slots = 0;
  int skip_after = 0;
  int bytes_taken = 0;
  int rise_cnt = 0;
  int rise_base, busy_cnt, cs_cnt, en_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Nibble / read-byte monitor; also feeds the next read nibble after each read rise.
  initial begin : monitor
    logic       sclk_prev;
    logic [7:0] e;
    logic [3:0] dummy;
    sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sclk_prev = 1'b0;
      end else begin
        if (sclk && !sclk_prev) begin
          rise_cnt++;
          if (exp_nib.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL nib_extra: got oe/dq 0x%0h, required no SCLK rise", {dq_oe, dq_out});
          end else begin
            e = exp_nib.pop_front();
            check("nibble_oe_dq", {24'h0, dq_oe, dq_out}, {24'h0, e});
          end
          if (dq_oe == 4'b0000 && rd_in.size() > 0) begin
            dummy = rd_in.pop_front();
            dq_in = (rd_in.size() > 0) ? rd_in[0] : 4'h0;
          end
        end
        if (rd_vld) begin
          if (exp_rd.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_extra: got rd_data 0x%0h, required no rd_vld", rd_data);
          end else begin
            e = exp_rd.pop_front();
            check("rd_data", {24'h0, rd_data}, {24'h0, e});
          end
        end
        sclk_prev = sclk;
      end
    end
  end

  // Write-data source with optional withholding of wr_vld for a number of slots.
  initial begin : wr_driver
    logic       tp, sk;
    logic [7:0] dummy;
    wr_vld  = 1'b0;
    wr_data = 8'h00;
    forever begin
      @(negedge clk);
      tp = wr_vld && clk_en && wr_ready;
      sk = !wr_vld && clk_en && wr_ready && (skip_slots > 0);
      @(posedge clk);
      #1;
      if (tp && wr_q.size() > 0) begin
        dummy = wr_q.pop_front();
        bytes_taken++;
      end
      if (sk) skip_slots--;
      wr_vld  = (wr_q.size() > 0) && !((skip_slots > 0) && (bytes_taken == skip_after));
      wr_data = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    end
  end

  task automatic push_nib(input logic [3:0] oe, input logic [3:0] dq);
    exp_nib.push_back({oe, dq});
  endtask

  task automatic start_req(input logic [1:0] lm, input logic [2:0] cmd, input int len,
                           input int wlen, input string tag);
    logic got;
    @(negedge clk);
    lane_mode   = lm;
    req_cmd     = cmd;
    req_len     = 24'(len);
    req_wr_len  = 24'(wlen);
    request     = 1'b1;
    bytes_taken = 0;
    dq_in       = (rd_in.size() > 0) ? rd_in[0] : 4'h0;
    rise_base   = rise_cnt;
    got         = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    request = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_accept: got busy=0 after 20 clocks, required busy=1", tag);
    end
    busy_cnt = 1;
    cs_cnt   = (cs_n == 1'b0) ? 1 : 0;
    en_cnt   = clk_en ? 1 : 0;
  endtask

  task automatic finish_req(input int e_busy, input int e_cs, input int e_en, input int e_rise,
                            input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      if (!cs_n) cs_cnt++;
      if (clk_en) en_cnt++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_done: got busy=1 after 3000 clocks, required busy=0", tag);
    end
    check({tag, "_busy_len"}, busy_cnt, e_busy);
    check({tag, "_cs_low_len"}, cs_cnt, e_cs);
    check({tag, "_clk_en_cnt"}, en_cnt, e_en);
    check({tag, "_sclk_rises"}, rise_cnt - rise_base, e_rise);
    check({tag, "_nib_left"}, exp_nib.size(), 0);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
  endtask

  task automatic load_t1();
    wr_q.push_back(8'h61);
    wr_q.push_back(8'h47);
    push_nib(4'hf, 4'h6);
    push_nib(4'hf, 4'h1);
    push_nib(4'hf, 4'h4);
    push_nib(4'hf, 4'h7);
  endtask

  initial begin
    logic [15:0] v;
    logic        got;
    rst        = 1'b1;
    request    = 1'b0;
    lane_mode  = 2'd0;
    req_cmd    = 3'd0;
    req_len    = '0;
    req_wr_len = '0;
    dq_in      = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_rd", {rd_vld, rd_data}, 0);
    check("rst_wr_ready_clk_en", {wr_ready, clk_en}, 0);
    rst = 1'b0;

    // X4 write of two bytes.
    load_t1();
    start_req(2'd2, 3'b000, 4, 4, "x4_wr");
    finish_req(24, 20, 2, 4, "x4_wr");

    // X1 forced by req_cmd bit0; nibble bit0 carries 0x6147 MSB first.
    v = 16'h6147;
    for (int b = 0; b < 8; b++) wr_q.push_back({3'b000, v[15-2*b], 3'b000, v[14-2*b]});
    for (int i = 15; i >= 0; i--) push_nib(4'h1, {3'b000, v[i]});
    start_req(2'd2, 3'b001, 16, 16, "x1_wr");
    finish_req(72, 68, 8, 16, "x1_wr");

    // X2: one write byte then four reads; upper dq_in bits must be ignored.
    wr_q.push_back(8'ha5);
    push_nib(4'h3, 4'ha);
    push_nib(4'h3, 4'h5);
    for (int i = 0; i < 4; i++) push_nib(4'h0, 4'h0);
    rd_in.push_back(4'hd);
    rd_in.push_back(4'he);
    rd_in.push_back(4'h7);
    rd_in.push_back(4'hc);
    exp_rd.push_back(8'h12);
    exp_rd.push_back(8'h30);
    start_req(2'd1, 3'b000, 6, 2, "x2_rd");
    finish_req(32, 28, 3, 6, "x2_rd");

    // X4 write with wr_vld withheld for 3 slots after two bytes.
    wr_q.push_back(8'h12);
    wr_q.push_back(8'h34);
    wr_q.push_back(8'h56);
    wr_q.push_back(8'h78);
    for (int i = 1; i <= 8; i++) push_nib(4'hf, 4'(i));
    skip_after = 2;
    skip_slots = 3;
    start_req(2'd2, 3'b000, 8, 8, "stall");
    finish_req(52, 48, 7, 8, "stall");
    check("stall_slots_used", skip_slots, 0);

    // Zero-length request never touches CS#.
    start_req(2'd2, 3'b000, 0, 0, "len0");
    finish_req(5, 0, 0, 0, "len0");

    // Odd X1 read (lane_mode 3 behaves as X1), data taken from DQ1.
    for (int i = 0; i < 3; i++) push_nib(4'h0, 4'h0);
    rd_in.push_back(4'b0010);
    rd_in.push_back(4'b1101);
    rd_in.push_back(4'b0010);
    exp_rd.push_back(8'h10);
    exp_rd.push_back(8'h10);
    start_req(2'd3, 3'b000, 3, 0, "x1_rd_odd");
    finish_req(20, 16, 2, 3, "x1_rd_odd");

    // Odd write length: low nibble of last byte dropped, read starts a fresh byte.
    wr_q.push_back(8'h9c);
    wr_q.push_back(8'h3f);
    push_nib(4'h3, 4'h9);
    push_nib(4'h3, 4'hc);
    push_nib(4'h3, 4'h3);
    push_nib(4'h0, 4'h0);
    rd_in.push_back(4'he);
    exp_rd.push_back(8'h20);
    start_req(2'd1, 3'b000, 4, 3, "odd_wlen");
    finish_req(24, 20, 2, 4, "odd_wlen");

    // Reset in the middle of SHIFT.
    for (int i = 0; i < 4; i++) wr_q.push_back(8'h5a);
    for (int i = 0; i < 8; i++) push_nib(4'hf, (i % 2 == 0) ? 4'h5 : 4'ha);
    start_req(2'd2, 3'b000, 8, 8, "rst_mid");
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rise_cnt - rise_base >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_shift", got, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_dq_oe", dq_oe, 0);
    rst = 1'b0;
    exp_nib.delete();
    exp_rd.delete();
    wr_q.delete();
    rd_in.delete();
    dq_in = 4'h0;
    repeat (3) @(negedge clk);

    load_t1();
    start_req(2'd2, 3'b000, 4, 4, "after_rst");
    finish_req(24, 20, 2, 4, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
